if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the five-stage MIPS32 pipeline. Owns the program counter, drives the address into the combinational instruction ROM, and captures the returned word into the IF/ID pipeline register. It applies redirects from later stages, interrupt and exception vectoring, and hazard-unit stall and flush requests under a fixed priority.

## Interface
- `RESET_PC`, 32'h0040_0000, PC value loaded on reset (user text base).
- `IRQ_VEC`, 32'h8000_0004, interrupt handler entry.
- `EXC_VEC`, 32'h8000_0008, exception (illegal op) handler entry.
- `clk` in 1, single clock, rising edge.
- `reset` in 1, asynchronous, active-low.
- `stall_if` in 1, hazard unit: hold PC and IF/ID.
- `flush_if` in 1, hazard unit: load a bubble into IF/ID.
- `redirect_valid` in 1, resolved branch/jump/jr from ID or EX.
- `redirect_pc` in 32, target for `redirect_valid`.
- `irq` in 1, external interrupt request, level-sensitive.
- `exception` in 1, exception detected downstream.
- `inst_addr` out 32, address to the instruction ROM; equals `pc`.
- `inst` in 32, ROM data, valid in the same cycle as `inst_addr`.
- `pc` out 32, current fetch PC.
- `ifid_inst` out 32, registered instruction.
- `ifid_pc_plus4` out 32, registered PC+4 of that instruction, used for link and branch base.
- `ifid_valid` out 1, 0 marks a bubble.

## Operation
- `pc_plus4` = {pc[31], pc[30:0]+4}.
  - Bit 31 is the kernel flag and is never carried into or cleared by the increment.
  - Bits 30:0 wrap modulo 2^31.
- Next-PC priority, highest first:
  - `exception`: next PC = `EXC_VEC`.
  - `irq` when pc[31]=0: next PC = `IRQ_VEC`.
  - `redirect_valid`: next PC = `redirect_pc`.
  - `stall_if`: next PC = `pc`.
  - Otherwise: next PC = `pc_plus4`.
- `irq` is ignored while pc[31]=1 (kernel mode, no nesting).
- Redirect, irq and exception override `stall_if` for the PC update.
- IF/ID update priority, highest first:
  - Bubble (`ifid_inst`=0, `ifid_pc_plus4`=0, `ifid_valid`=0) when any of these holds: `exception`, a taken `irq`, `redirect_valid`, `flush_if`.
  - Hold when `stall_if`.
  - Otherwise load `inst`, `pc_plus4`, `ifid_valid`=1.
- For a taken irq, the interrupted instruction's return address is the PC+4 of the youngest instruction already past IF. The pipeline computes it downstream; this block only vectors.
- `redirect_pc` bits 1:0 are forced to 0 before loading the PC.
- Outputs follow the registers with no combinational path from `inst`, except `inst_addr`=`pc`.

## Timing
- Reset asserted (asynchronous): `pc`=`RESET_PC`, `ifid_inst`=0, `ifid_pc_plus4`=0, `ifid_valid`=0.
- First cycle after deassertion: ROM is read at `RESET_PC`. The word appears on `ifid_inst` one edge later.
- Fetch latency is 1 cycle: an instruction at `inst_addr` in cycle N is on `ifid_inst` in N+1.
- Redirect asserted in cycle N:
  - `pc` = target at N+1.
  - IF/ID holds a bubble at N+1.
  - Target instruction is in IF/ID at N+2.
- Stall and flush in the same cycle: bubble, and PC held.
- Stall held for k cycles: `pc` and IF/ID remain constant k cycles, then sequential fetch resumes.
- Reset asserted mid-stall or mid-redirect: immediate return to reset values, with no pending state retained.

## Structure
- Shared package (`cpu_defs`): `RESET_PC`, `IRQ_VEC`, `EXC_VEC`, `NOP`=32'h0, and the kernel-bit index 31.
- One natural sub-module, `pc_next_sel`: the combinational next-PC priority mux and `pc_plus4` adder.
- The PC and IF/ID registers stay in `if_stage`.

## Test plan
- Reset then free-run with a ROM returning addr+1:
  - `pc` goes 0x00400000, 0x00400004, 0x00400008.
  - `ifid_inst` = 0x00400001 then 0x00400005.
  - `ifid_valid` rises one cycle after reset release.
- `stall_if`=1 for 3 cycles at pc=0x0040000C: `pc` and `ifid_inst` frozen, then 0x00400010 is fetched.
- `redirect_valid` with `redirect_pc`=0x00400100 while `stall_if`=1:
  - Next `pc`=0x00400100 with a bubble in IF/ID.
  - 0x00400101 appears the following cycle.
- `irq` at pc=0x00400020: next `pc`=0x80000004, bubble. At pc=0x80000004, `irq` held high gives `pc`=0x80000008, no re-vector.
- `exception` and `redirect_valid` in the same cycle: `pc`=0x80000008.
- pc=0xFFFFFFFC, no control inputs: next `pc`=0x80000000 (bit 31 kept). Assert reset mid-run: all outputs return to reset values asynchronously, before the next edge.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared definitions for the MIPS32 fetch path: reset/vector addresses, bubble
// encoding and the kernel-mode PC increment.
package cpu_defs;

   localparam logic [31:0] RESET_PC   = 32'h0040_0000;
   localparam logic [31:0] IRQ_VEC    = 32'h8000_0004;
   localparam logic [31:0] EXC_VEC    = 32'h8000_0008;
   localparam logic [31:0] NOP        = 32'h0000_0000;
   localparam int          KERNEL_BIT = 31;

   typedef enum logic [2:0] {
      SRC_SEQ   = 3'd0,
      SRC_HOLD  = 3'd1,
      SRC_REDIR = 3'd2,
      SRC_IRQ   = 3'd3,
      SRC_EXC   = 3'd4
   } pc_src_e;

   // The kernel flag rides along untouched; only the low 31 bits count.
   function automatic logic [31:0] pc_inc(input logic [31:0] pc);
      return {pc[KERNEL_BIT], pc[30:0] + 31'd4};
   endfunction

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_stage_pc_next_sel.sv
// Combinational next-PC selection: fixed-priority mux over exception, interrupt,
// redirect, stall and sequential fetch, plus the PC+4 adder.
module pc_next_sel
   import cpu_defs::*;
(
   input  logic [31:0] pc,
   input  logic        exception,
   input  logic        irq,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        stall_if,
   output logic [31:0] next_pc,
   output logic [31:0] pc_plus4,
   output logic        irq_taken,
   output pc_src_e     src
);

   // Priority decode of the PC source; irq is masked in kernel mode.
   always_comb begin
      pc_plus4  = pc_inc(pc);
      irq_taken = irq & ~pc[KERNEL_BIT];
      src       = SRC_SEQ;
      if (exception) begin
         src = SRC_EXC;
      end else if (irq_taken) begin
         src = SRC_IRQ;
      end else if (redirect_valid) begin
         src = SRC_REDIR;
      end else if (stall_if) begin
         src = SRC_HOLD;
      end else begin
         src = SRC_SEQ;
      end
   end

   // Next-PC value for the selected source.
   always_comb begin
      next_pc = pc_plus4;
      case (src)
         SRC_EXC:   next_pc = EXC_VEC;
         SRC_IRQ:   next_pc = IRQ_VEC;
         SRC_REDIR: next_pc = word_align(redirect_pc);
         SRC_HOLD:  next_pc = pc;
         SRC_SEQ:   next_pc = pc_plus4;
         default:   next_pc = pc_plus4;
      endcase
   end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, ROM addressing and the IF/ID
// pipeline register, with redirect/vector/stall/flush handling.
module if_stage
   import cpu_defs::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_if,
   input  logic        flush_if,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        irq,
   input  logic        exception,
   output logic [31:0] inst_addr,
   input  logic [31:0] inst,
   output logic [31:0] pc,
   output logic [31:0] ifid_inst,
   output logic [31:0] ifid_pc_plus4,
   output logic        ifid_valid
);

   logic [31:0] next_pc;
   logic [31:0] pc_plus4;
   logic        irq_taken;
   pc_src_e     src;
   logic        bubble;

   pc_next_sel u_pc_next_sel (
      .pc             (pc),
      .exception      (exception),
      .irq            (irq),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .stall_if       (stall_if),
      .next_pc        (next_pc),
      .pc_plus4       (pc_plus4),
      .irq_taken      (irq_taken),
      .src            (src)
   );

   assign inst_addr = pc;

   // Any control-flow change discards the word currently being fetched.
   always_comb begin
      bubble = exception | irq_taken | redirect_valid | flush_if;
   end

   // Program counter register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc <= RESET_PC;
      end else begin
         pc <= next_pc;
      end
   end

   // IF/ID pipeline register: bubble beats hold beats load.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ifid_inst     <= NOP;
         ifid_pc_plus4 <= 32'h0000_0000;
         ifid_valid    <= 1'b0;
      end else if (bubble) begin
         ifid_inst     <= NOP;
         ifid_pc_plus4 <= 32'h0000_0000;
         ifid_valid    <= 1'b0;
      end else if (stall_if) begin
         ifid_inst     <= ifid_inst;
         ifid_pc_plus4 <= ifid_pc_plus4;
         ifid_valid    <= ifid_valid;
      end else begin
         ifid_inst     <= inst;
         ifid_pc_plus4 <= pc_plus4;
         ifid_valid    <= 1'b1;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed per-cycle vectors push hand-computed
// expectations; a monitor pops and compares after each edge or reset assertion.
module tb_if_stage;

   logic        clk;
   logic        reset;
   logic        stall_if;
   logic        flush_if;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        irq;
   logic        exception;
   logic [31:0] inst_addr;
   logic [31:0] inst;
   logic [31:0] pc;
   logic [31:0] ifid_inst;
   logic [31:0] ifid_pc_plus4;
   logic        ifid_valid;

   if_stage dut (
      .clk            (clk),
      .reset          (reset),
      .stall_if       (stall_if),
      .flush_if       (flush_if),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .irq            (irq),
      .exception      (exception),
      .inst_addr      (inst_addr),
      .inst           (inst),
      .pc             (pc),
      .ifid_inst      (ifid_inst),
      .ifid_pc_plus4  (ifid_pc_plus4),
      .ifid_valid     (ifid_valid)
   );

   // ROM model: each word holds its own address plus one.
   assign inst = inst_addr + 32'd1;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int          tag;
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] pc4;
      logic        valid;
   } exp_t;

   typedef struct {
      logic        stall;
      logic        flush;
      logic        rv;
      logic [31:0] rpc;
      logic        irq;
      logic        exc;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
      logic [31:0] e_pc4;
      logic        e_v;
   } vec_t;

   exp_t exp_q[$];
   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(input logic s, input logic f, input logic r,
                               input logic [31:0] rp, input logic i, input logic e,
                               input logic [31:0] p, input logic [31:0] ins,
                               input logic [31:0] p4, input logic v);
      vec_t x;
      x.stall = s;  x.flush = f;  x.rv = r;  x.rpc = rp;  x.irq = i;  x.exc = e;
      x.e_pc = p;   x.e_inst = ins;  x.e_pc4 = p4;  x.e_v = v;
      return x;
   endfunction

   function automatic exp_t mk_exp(input int tag, input logic [31:0] p,
                                   input logic [31:0] ins, input logic [31:0] p4,
                                   input logic v);
      exp_t x;
      x.tag = tag;  x.pc = p;  x.inst = ins;  x.pc4 = p4;  x.valid = v;
      return x;
   endfunction

   task automatic chk(input string nm, input int tag, input logic [31:0] act,
                      input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s tag=%0d actual=%h required=%h", nm, tag, act, expv);
      end
   endtask

   task automatic drive(input vec_t v);
      stall_if       = v.stall;
      flush_if       = v.flush;
      redirect_valid = v.rv;
      redirect_pc    = v.rpc;
      irq            = v.irq;
      exception      = v.exc;
   endtask

   // Monitor: compare after every active edge and every reset assertion.
   initial begin
      exp_t ex;
      forever begin
         @(posedge clk or negedge reset);
         #1;
         if (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            chk("pc",            ex.tag, pc,            ex.pc);
            chk("inst_addr",     ex.tag, inst_addr,     ex.pc);
            chk("ifid_inst",     ex.tag, ifid_inst,     ex.inst);
            chk("ifid_pc_plus4", ex.tag, ifid_pc_plus4, ex.pc4);
            chk("ifid_valid",    ex.tag, {31'd0, ifid_valid}, {31'd0, ex.valid});
         end
      end
   end

   // Stimulus: one vector per cycle, driven on the falling edge.
   initial begin
      vec_t idle;
      idle = mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      //          stall flush rv    rpc           irq   exc   pc            inst          pc4           v
      vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0040_0004, 32'h0040_0001, 32'h0040_0004, 1'b1));
      vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0040_0008, 32'h0040_0005, 32'h0040_0008, 1'b1));
      vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0040_000C, 32'h0040_0009, 32'h0040_000C, 1'b1));
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0040_000C, 32'h0040_0009, 32'h0040_000C, 1'b1));
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0040_000C, 32'h0040_0009, 32'h0040_000C, 1'b1));
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0040_000C, 32'h0040_0009, 32'h0040_000C, 1'b1));
      vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0040_0010, 32'h0040_000D, 32'h0040_0010, 1'b1));
      vecs.push_back(mk(1'b1, 1'b0, 1'b1, 32'h0040_0100, 1'b0, 1'b0, 32'h0040_0100, 32'h0,        32'h0,         1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0040_0104, 32'h0040_0101, 32'h0040_0104, 1'b1));
      vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h0040_0020, 1'b0, 1'b0, 32'h0040_0020, 32'h0,        32'h0,         1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h8000_0004, 32'h0,         32'h0,         1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h8000_0008, 32'h8000_0005, 32'h8000_0008, 1'b1));
      vecs.push_back(mk(1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h8000_0008, 32'h0,         32'h0,         1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h0040_0200, 1'b0, 1'b1, 32'h8000_0008, 32'h0,        32'h0,         1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,        32'h0,         1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFD, 32'h8000_0000, 1'b1));
      vecs.push_back(mk(1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h8000_0004, 32'h8000_0001, 32'h8000_0004, 1'b1));
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h8000_0008, 32'h0,         32'h0,         1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 1'b1, 32'h0040_0040, 1'b0, 1'b0, 32'h0040_0040, 32'h0,        32'h0,         1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 1'b0, 32'h8000_0004, 32'h0,         32'h0,         1'b0));

      reset = 1'b0;
      drive(idle);
      @(negedge clk);
      exp_q.push_back(mk_exp(100, 32'h0040_0000, 32'h0, 32'h0, 1'b0));
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i]);
         exp_q.push_back(mk_exp(i, vecs[i].e_pc, vecs[i].e_inst, vecs[i].e_pc4, vecs[i].e_v));
         @(negedge clk);
      end

      // Reset dropped mid-cycle during a stall with a pending redirect.
      drive(mk(1'b1, 1'b0, 1'b1, 32'h0040_0300, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0));
      exp_q.push_back(mk_exp(200, 32'h0040_0000, 32'h0, 32'h0, 1'b0));
      #2 reset = 1'b0;
      @(negedge clk);
      drive(idle);
      exp_q.push_back(mk_exp(201, 32'h0040_0000, 32'h0, 32'h0, 1'b0));
      @(negedge clk);
      reset = 1'b1;
      exp_q.push_back(mk_exp(202, 32'h0040_0004, 32'h0040_0001, 32'h0040_0004, 1'b1));
      @(negedge clk);
      exp_q.push_back(mk_exp(203, 32'h0040_0008, 32'h0040_0005, 32'h0040_0008, 1'b1));
      @(negedge clk);

      for (int n = 0; n < 20 && exp_q.size() > 0; n++) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain actual=%0d pending required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
